// File: rtl/obi_pkg.sv
// Shared types for the OBI subordinate memory: the response-buffer entry
// and the all-bytes-enabled constant.
package obi_pkg;

    localparam int         OBI_DW     = 32;
    localparam int         OBI_BEW    = OBI_DW / 8;
    localparam logic [3:0] OBI_BE_ALL = 4'b1111;

    typedef struct packed {
        logic [OBI_DW-1:0] rdata;
        logic              err;
    } obi_rsp_t;

endpackage

// File: rtl/obi_rsp_fifo.sv
// Response buffer: circular store of {rdata, err} entries, pointers wrap
// modulo DEPTH and occupancy is tracked by a separate counter.
module obi_rsp_fifo
    import obi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     reset_ni,
    input  logic     push_i,
    input  obi_rsp_t data_i,
    input  logic     pop_i,
    output obi_rsp_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    obi_rsp_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset: the read side is gated by empty_o.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/obi_sbr_mem.sv
// OBI subordinate backed by a small word-addressed memory with per-byte
// write enables; one response per accepted transaction, 1-cycle latency.
module obi_sbr_mem
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH);
    // Address bits at or above 2+IW must be zero for a legal access.
    localparam logic [ADDR_WIDTH-1:0] IN_RANGE = ADDR_WIDTH'(DEPTH * 4 - 1);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [IW-1:0]                    idx;
    logic                             addr_err;
    logic                             accept;
    logic                             wr_en;
    logic                             fifo_full;
    logic                             fifo_empty;
    obi_rsp_t                         rsp_d;
    obi_rsp_t                         rsp_q;

    assign idx      = obi_addr_i[2+IW-1:2];
    assign addr_err = (obi_addr_i[1:0] != 2'b00) || ((obi_addr_i & ~IN_RANGE) != '0);

    assign obi_gnt_o = obi_req_i && !fifo_full;
    assign accept    = obi_req_i && obi_gnt_o;
    assign wr_en     = accept && obi_we_i && !addr_err;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_q <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BW; b++) begin
                if (obi_be_i[b]) mem_q[idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
            end
        end
    end

    // Writes and errors return zero data; reads see storage as of this cycle.
    always_comb begin
        rsp_d       = '0;
        rsp_d.err   = addr_err;
        if (!obi_we_i && !addr_err) rsp_d.rdata = mem_q[idx];
    end

    obi_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (accept),
        .data_i   (rsp_d),
        .pop_i    (obi_rvalid_o && obi_rready_i),
        .data_o   (rsp_q),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    assign obi_rvalid_o = !fifo_empty;
    assign obi_rdata_o  = obi_rvalid_o ? rsp_q.rdata : '0;
    assign obi_err_o    = obi_rvalid_o ? rsp_q.err   : 1'b0;

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Directed bench for obi_sbr_mem: inputs driven on the falling edge,
// outputs checked 1 time unit later.
module tb_obi_sbr_mem;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    obi_sbr_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .RSP_DEPTH  (2)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rready_i (obi_rready_i),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        obi_req_i   = req;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_be_i    = be;
        obi_wdata_i = wdata;
    endtask

    // One transaction with rready=1: grant same cycle, response next cycle.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk_i);
        drive(1'b1, we, addr, be, wdata);
        #1 chk({tag, ".gnt"}, 32'(obi_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk({tag, ".rvalid"}, 32'(obi_rvalid_o), 32'd1);
        chk({tag, ".rdata"}, obi_rdata_o, exp_rdata);
        chk({tag, ".err"}, 32'(obi_err_o), 32'(exp_err));
    endtask

    initial begin
        reset_ni     = 1'b0;
        obi_rready_i = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rst.gnt_follows_req", 32'(obi_gnt_o), 32'd1);
        chk("rst.rvalid", 32'(obi_rvalid_o), 32'd0);
        chk("rst.rdata", obi_rdata_o, 32'd0);
        chk("rst.err", 32'(obi_err_o), 32'd0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // Full-word write then read back
        xfer("wr04", 1'b1, 32'h04, 4'hF, 32'h1000_00AA, 32'h0, 1'b0);
        xfer("rd04", 1'b0, 32'h04, 4'h0, 32'h0, 32'h1000_00AA, 1'b0);

        // Partial byte write merges into existing word
        xfer("wr08", 1'b1, 32'h08, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xfer("wr08b1", 1'b1, 32'h08, 4'b0010, 32'h0000_1200, 32'h0, 1'b0);
        xfer("rd08", 1'b0, 32'h08, 4'h0, 32'h0, 32'hDEAD_12EF, 1'b0);
        xfer("wr08be0", 1'b1, 32'h08, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xfer("rd08b", 1'b0, 32'h08, 4'hF, 32'h0, 32'hDEAD_12EF, 1'b0);

        // Error cases: misaligned and out of range leave storage untouched
        xfer("rd02", 1'b0, 32'h02, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer("rd40", 1'b0, 32'h40, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer("wr06", 1'b1, 32'h06, 4'hF, 32'h5555_5555, 32'h0, 1'b1);
        xfer("wr44", 1'b1, 32'h44, 4'hF, 32'h6666_6666, 32'h0, 1'b1);
        xfer("rd04b", 1'b0, 32'h04, 4'h0, 32'h0, 32'h1000_00AA, 1'b0);

        // Read the cycle right after a write to the same word
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h0C, 4'hF, 32'h1234_5678);
        #1 chk("raw.wr_gnt", 32'(obi_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0C, 4'hF, 32'h0);
        #1;
        chk("raw.rd_gnt", 32'(obi_gnt_o), 32'd1);
        chk("raw.wr_rdata", obi_rdata_o, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1 chk("raw.rd_rdata", obi_rdata_o, 32'h1234_5678);

        // Backpressure: 3 back-to-back reads against a 2-entry buffer
        @(negedge clk_i);
        obi_rready_i = 1'b0;
        #1 chk("bp.idle_rvalid", 32'(obi_rvalid_o), 32'd0);
        chk("bp.idle_rdata", obi_rdata_o, 32'd0);
        drive(1'b1, 1'b0, 32'h04, 4'hF, 32'h0);
        #1 chk("bp.gnt1", 32'(obi_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h08, 4'hF, 32'h0);
        #1;
        chk("bp.gnt2", 32'(obi_gnt_o), 32'd1);
        chk("bp.head1", obi_rdata_o, 32'h1000_00AA);
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0C, 4'hF, 32'h0);
        #1;
        chk("bp.gnt3_blocked", 32'(obi_gnt_o), 32'd0);
        chk("bp.head1_held", obi_rdata_o, 32'h1000_00AA);
        obi_rready_i = 1'b1;
        #1 chk("bp.gnt_ignores_pop", 32'(obi_gnt_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk("bp.gnt3", 32'(obi_gnt_o), 32'd1);
        chk("bp.head2", obi_rdata_o, 32'hDEAD_12EF);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1 chk("bp.head3", obi_rdata_o, 32'h1234_5678);
        @(negedge clk_i);
        #1;
        chk("bp.drained_rvalid", 32'(obi_rvalid_o), 32'd0);
        chk("bp.drained_err", 32'(obi_err_o), 32'd0);

        // Reset with responses pending; a write granted at the reset edge is lost
        obi_rready_i = 1'b0;
        drive(1'b1, 1'b0, 32'h04, 4'hF, 32'h0);
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h08, 4'hF, 32'h0);
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h04, 4'hF, 32'hFFFF_FFFF);
        #1 chk("arst.pending_rvalid", 32'(obi_rvalid_o), 32'd1);
        #1 reset_ni = 1'b0;
        #1;
        chk("arst.rvalid", 32'(obi_rvalid_o), 32'd0);
        chk("arst.rdata", obi_rdata_o, 32'd0);
        chk("arst.gnt", 32'(obi_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        reset_ni     = 1'b1;
        obi_rready_i = 1'b1;
        xfer("post_rd04", 1'b0, 32'h04, 4'hF, 32'h0, 32'h0, 1'b0);
        xfer("post_rd08", 1'b0, 32'h08, 4'hF, 32'h0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_sbr_mem.md
OBI_SBR_MEM -- requirements
Module: obi_sbr_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width; only 32 is supported.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of storage words (power of two, at least 2).
REQ-004 SHALL have parameter RSP_DEPTH, default 2, meaning response buffer entries (at least 1).
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-006 SHALL have port reset_ni, input, 1 bit, the asynchronous active-low reset.
REQ-007 SHALL have port obi_req_i, input, 1 bit, A-channel request.
REQ-008 SHALL have port obi_gnt_o, output, 1 bit, A-channel grant.
REQ-009 SHALL have port obi_addr_i, input, ADDR_WIDTH bits, byte address.
REQ-010 SHALL have port obi_we_i, input, 1 bit, write enable (1 = write).
REQ-011 SHALL have port obi_be_i, input, DATA_WIDTH/8 bits, byte enables.
REQ-012 SHALL have port obi_wdata_i, input, DATA_WIDTH bits, write data.
REQ-013 SHALL have port obi_rvalid_o, output, 1 bit, R-channel valid.
REQ-014 SHALL have port obi_rready_i, input, 1 bit, R-channel ready.
REQ-015 SHALL have port obi_rdata_o, output, DATA_WIDTH bits, read data.
REQ-016 SHALL have port obi_err_o, output, 1 bit, response error.

Function
REQ-017 SHALL drive obi_gnt_o = obi_req_i AND (buffer count < RSP_DEPTH), combinationally; a grant never depends on a same-cycle pop.
REQ-018 SHALL treat a cycle with obi_req_i=1 and obi_gnt_o=1 as an accepted transaction, and SHALL perform the storage access at the rising edge ending that cycle.
REQ-019 SHALL decode word index = addr[2+log2(DEPTH)-1:2]; a transaction is in error if addr[1:0] != 0 or any address bit at or above 2+log2(DEPTH) is set.
REQ-020 SHALL, on an accepted error-free write, update only the bytes with be=1; when be=0000 the write completes with no change to storage.
REQ-021 SHALL, on an accepted error-free read, return the full word regardless of be.
REQ-022 SHALL, on an error transaction, leave storage unmodified and respond with err=1 and rdata=0.
REQ-023 SHALL respond to an accepted write with rdata=0 and err per REQ-022.
REQ-024 SHALL push one {rdata, err} entry per accepted transaction; obi_rvalid_o SHALL equal (count != 0), first asserting the cycle after the grant (1-cycle latency).
REQ-025 SHALL hold obi_rdata_o and obi_err_o stable while obi_rvalid_o=1 and obi_rready_i=0, and SHALL pop the entry when obi_rvalid_o=1 and obi_rready_i=1.
REQ-026 SHALL return responses in acceptance order.
REQ-027 SHALL apply a simultaneous push and pop with count unchanged; when full, the pop takes effect and the grant stays low that cycle.
REQ-028 SHALL make a read accepted the cycle after a write to the same word return the newly written data.
REQ-029 SHALL drive obi_rdata_o=0 and obi_err_o=0 whenever obi_rvalid_o=0.

Reset
REQ-030 SHALL, while reset_ni=0, clear the response buffer (count=0, pointers=0) and all storage words to 0, independent of clk_i.
REQ-031 SHALL force obi_rvalid_o=0, obi_rdata_o=0 and obi_err_o=0 during reset; obi_gnt_o SHALL follow obi_req_i.
REQ-032 SHALL discard buffered responses on reset mid-operation, and a write whose grant edge coincides with reset assertion SHALL have no effect.

Structure
REQ-033 SHALL place the response entry struct type {rdata, err} and a shared OBI_BE_ALL constant in the package obi_pkg.
REQ-034 SHALL implement the response buffer as the sub-module obi_rsp_fifo, with pointers that wrap modulo RSP_DEPTH and a separate count.

Verification
REQ-035 SHALL cover: write 0x1000_00AA to 0x04 with be=1111, then read 0x04 -> gnt same cycle, rvalid the next cycle, rdata=0x1000_00AA, err=0.
REQ-036 SHALL cover: write 0xDEAD_BEEF to 0x08 with be=1111, write 0x0000_1200 to 0x08 with be=0010, then read 0x08 -> rdata=0xDEAD_12EF.
REQ-037 SHALL cover: read 0x02 (misaligned) and read 0x40 with DEPTH=16 (out of range) -> err=1, rdata=0 for each, and storage unchanged.
REQ-038 SHALL cover: hold rready=0 while issuing 3 back-to-back reads with RSP_DEPTH=2 -> gnt high on the first two, low on the third; raising rready pops one entry, the third is granted the next cycle, and responses return in order.
REQ-039 SHALL cover: assert reset_ni=0 asynchronously with 2 responses pending -> rvalid=0 immediately; after release, read 0x04 -> rdata=0.
